dmem_lsu: RTL

//  Load/store unit: the initiator that drives the byte-addressed DMEM port (wr_en/addr/wr_data/data_out).

---
 rtl/dmem_lsu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit driving a byte-addressed, word-write DMEM port; sub-word stores use read-modify-write.
// Optional macro MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module dmem_lsu #(
  parameter int REG_WIDTH       = 32,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DMEM_DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_store,
  input  logic [2:0]                 req_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]       req_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [REG_WIDTH-1:0]       resp_rdata,
  output logic                       resp_err,
  output logic                       dmem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]       dmem_wdata,
  input  logic [REG_WIDTH-1:0]       dmem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  localparam logic [DMEM_ADDR_WIDTH:0] ADDR_LIMIT = (DMEM_ADDR_WIDTH+1)'(DMEM_DEPTH - 4);

  state_t                     state_r, next_state_s;
  logic                       store_r;
  logic [2:0]                 funct3_r;
  logic                       accept_s, req_err_s;
  logic                       f3_bad_s, range_bad_s, align_bad_s;
  logic                       wr_en_d_s, resp_valid_d_s, resp_err_d_s;
  logic [DMEM_ADDR_WIDTH-1:0] addr_d_s;
  logic [REG_WIDTH-1:0]       wdata_d_s, rdata_d_s;

  function automatic logic [REG_WIDTH-1:0] format_load(input logic [2:0] f3, input logic [REG_WIDTH-1:0] rd);
    case (f3)
      3'b000:  format_load = {{24{rd[7]}}, rd[7:0]};
      3'b100:  format_load = {24'd0, rd[7:0]};
      3'b001:  format_load = {{16{rd[15]}}, rd[15:0]};
      3'b101:  format_load = {16'd0, rd[15:0]};
      default: format_load = rd;
    endcase
  endfunction

  function automatic logic [REG_WIDTH-1:0] merge_store(input logic [1:0] size, input logic [REG_WIDTH-1:0] rd,
                                                       input logic [REG_WIDTH-1:0] wd);
    case (size)
      2'b00:   merge_store = {rd[31:8], wd[7:0]};
      2'b01:   merge_store = {rd[31:16], wd[15:0]};
      default: merge_store = wd;
    endcase
  endfunction

  assign req_ready = (state_r == IDLE);
  assign accept_s  = req_valid && req_ready;

  // Request legality: funct3 encoding, range and (optionally) alignment
  always_comb begin
    if (req_store) begin
      f3_bad_s = (req_funct3 > 3'b010);
    end else begin
      f3_bad_s = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    range_bad_s = ({1'b0, req_addr} > ADDR_LIMIT);
    align_bad_s = 1'b0;
`ifdef MISALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   align_bad_s = req_addr[0];
      2'b10:   align_bad_s = |req_addr[1:0];
      default: align_bad_s = 1'b0;
    endcase
`endif
    req_err_s = f3_bad_s || range_bad_s || align_bad_s;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          next_state_s = IDLE;
        end else if (req_err_s) begin
          next_state_s = RESP;
        end else if (req_store && (req_funct3[1:0] == 2'b10)) begin
          next_state_s = WR;
        end else begin
          next_state_s = RD;
        end
      end
      RD:      next_state_s = store_r ? WR : RESP;
      WR:      next_state_s = RESP;
      RESP:    next_state_s = resp_ready ? IDLE : RESP;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; the store data rides in dmem_wdata until the merge
  always_comb begin
    wr_en_d_s      = (next_state_s == WR);
    resp_valid_d_s = (next_state_s == RESP);
    addr_d_s       = dmem_addr;
    wdata_d_s      = dmem_wdata;
    rdata_d_s      = resp_rdata;
    resp_err_d_s   = resp_err;
    case (state_r)
      IDLE: begin
        if (accept_s && req_err_s) begin
          rdata_d_s    = {REG_WIDTH{1'b0}};
          resp_err_d_s = 1'b1;
        end else if (accept_s) begin
          addr_d_s  = req_addr;
          wdata_d_s = req_store ? req_wdata : dmem_wdata;
        end else begin
          addr_d_s = dmem_addr;
        end
      end
      RD: begin
        resp_err_d_s = 1'b0;
        if (store_r) begin
          wdata_d_s = merge_store(funct3_r[1:0], dmem_rdata, dmem_wdata);
          rdata_d_s = {REG_WIDTH{1'b0}};
        end else begin
          rdata_d_s = format_load(funct3_r, dmem_rdata);
        end
      end
      WR: begin
        rdata_d_s    = {REG_WIDTH{1'b0}};
        resp_err_d_s = 1'b0;
      end
      RESP:    resp_err_d_s = resp_err;
      default: resp_err_d_s = resp_err;
    endcase
  end

  // Registered outputs and latched request attributes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_wr_en <= 1'b0;
      dmem_addr  <= {DMEM_ADDR_WIDTH{1'b0}};
      dmem_wdata <= {REG_WIDTH{1'b0}};
      resp_valid <= 1'b0;
      resp_rdata <= {REG_WIDTH{1'b0}};
      resp_err   <= 1'b0;
      store_r    <= 1'b0;
      funct3_r   <= 3'b000;
    end else begin
      dmem_wr_en <= wr_en_d_s;
      dmem_addr  <= addr_d_s;
      dmem_wdata <= wdata_d_s;
      resp_valid <= resp_valid_d_s;
      resp_rdata <= rdata_d_s;
      resp_err   <= resp_err_d_s;
      if (accept_s) begin
        store_r  <= req_store;
        funct3_r <= req_funct3;
      end
    end
  end

endmodule
